// File: rtl/det_pkg.sv
// Shared definitions for the 3x3 determinant engine and its matrix producers.
// Matrices are packed row-major with E[0][0] in the most significant slice.
package det_pkg;

  localparam int DIM      = 3;
  localparam int NUM_ELEM = DIM * DIM;
  // Widest element width the generic elem() helper can slice.
  localparam int MAX_W    = 64;

  // Width that holds any determinant of W-bit signed elements exactly.
  function automatic int det_full_w(input int w);
    return 3 * w + 2;
  endfunction

  // Bit position of the least significant bit of E[r][c] in a packed matrix.
  function automatic int elem_lsb(input int r, input int c, input int w);
    return (NUM_ELEM - 1 - DIM * r - c) * w;
  endfunction

  // Raw bits of E[r][c] (w <= MAX_W), zero-filled above bit w-1.
  function automatic logic [MAX_W-1:0] elem(input logic [NUM_ELEM*MAX_W-1:0] mat,
                                            input int r, input int c, input int w);
    logic [MAX_W-1:0] e;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) begin
        e[b] = mat[elem_lsb(r, c, w) + b];
      end else begin
        e[b] = 1'b0;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/det3_pipe_if.sv
// Valid/ready bundle between a matrix producer/result consumer and det3_pipe.
// out_singular exists only when DET3_SINGULAR_EN is defined.
interface det3_pipe_if
  import det_pkg::*;
#(
  parameter int W     = 32,
  parameter int OUT_W = 3 * W + 2
);

  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_ELEM*W-1:0]   in_matrix;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_det;
  logic                    out_ovf;
`ifdef DET3_SINGULAR_EN
  logic                    out_singular;
`endif

  // Environment side: supplies matrices and accepts results.
  modport master (
    output in_valid,
    output in_matrix,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_det,
`ifdef DET3_SINGULAR_EN
    input  out_singular,
`endif
    input  out_ovf
  );

  // Engine side.
  modport slave (
    input  in_valid,
    input  in_matrix,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_det,
`ifdef DET3_SINGULAR_EN
    output out_singular,
`endif
    output out_ovf
  );

endinterface

// File: rtl/det_minor2.sv
// Two-stage registered 2x2 minor a*d - b*c of signed W-bit operands.
// Stage 1 holds both 2W-bit products, stage 2 the 2W+1-bit difference.
module det_minor2 #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [2*W:0] m_o
);

  logic signed [2*W-1:0] ad_d, bc_d, ad_q, bc_q;
  logic signed [2*W:0]   m_d, m_q;

  // Full-width products and their sign-extended difference.
  always_comb begin
    ad_d = (2*W)'(a_i) * (2*W)'(d_i);
    bc_d = (2*W)'(b_i) * (2*W)'(c_i);
    m_d  = (2*W+1)'(ad_q) - (2*W+1)'(bc_q);
  end

  // Both stages advance together under the shared enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_q <= {(2*W){1'b0}};
      bc_q <= {(2*W){1'b0}};
      m_q  <= {(2*W+1){1'b0}};
    end else if (en_i) begin
      ad_q <= ad_d;
      bc_q <= bc_d;
      m_q  <= m_d;
    end
  end

  assign m_o = m_q;

endmodule

// File: rtl/det3_pipe.sv
// Pipelined signed 3x3 determinant engine, 4-cycle latency, one matrix per cycle.
// Cofactor expansion along row 0; a single advance signal stalls every stage.
// Optional build macro: DET3_SINGULAR_EN adds the registered out_singular flag.
module det3_pipe
  import det_pkg::*;
#(
  parameter int W     = 32,
  parameter int OUT_W = 3 * W + 2
) (
  input  logic         clk,
  input  logic         reset,
  det3_pipe_if.slave   bus
);

  localparam int FULL_W = det_full_w(W);
  localparam int M_W    = 2 * W + 1;
  localparam int P_W    = 3 * W + 1;

  logic adv_s;
  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d, v2_d, v3_d, v4_d;

  logic signed [W-1:0]      e_s [DIM][DIM];
  logic signed [W-1:0]      r0_s1_q [DIM];
  logic signed [W-1:0]      r0_s2_q [DIM];
  logic signed [M_W-1:0]    m_s [DIM];
  logic signed [P_W-1:0]    x_d, y_d, z_d, x_q, y_q, z_q;
  logic signed [FULL_W-1:0] d_s;
  logic signed [OUT_W-1:0]  det_trunc_s;
  logic                     ovf_s;
  logic [OUT_W-1:0]         det_q;
  logic                     ovf_q;

  // Unpack the incoming matrix into signed elements.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign e_s[r][c] = bus.in_matrix[elem_lsb(r, c, W) +: W];
    end
  end

  // S1/S2: the three row-0 cofactor minors.
  det_minor2 #(.W(W)) u_minor0 (
    .clk   (clk),
    .reset (reset),
    .en_i  (adv_s),
    .a_i   (e_s[1][1]),
    .b_i   (e_s[1][2]),
    .c_i   (e_s[2][1]),
    .d_i   (e_s[2][2]),
    .m_o   (m_s[0])
  );

  det_minor2 #(.W(W)) u_minor1 (
    .clk   (clk),
    .reset (reset),
    .en_i  (adv_s),
    .a_i   (e_s[1][0]),
    .b_i   (e_s[1][2]),
    .c_i   (e_s[2][0]),
    .d_i   (e_s[2][2]),
    .m_o   (m_s[1])
  );

  det_minor2 #(.W(W)) u_minor2 (
    .clk   (clk),
    .reset (reset),
    .en_i  (adv_s),
    .a_i   (e_s[1][0]),
    .b_i   (e_s[1][1]),
    .c_i   (e_s[2][0]),
    .d_i   (e_s[2][1]),
    .m_o   (m_s[2])
  );

  // Global advance and next stage valids; bubbles move forward on advance.
  always_comb begin
    adv_s = !v4_q || bus.out_ready;
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    v4_d  = v4_q;
    if (adv_s) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      v4_d = v3_q;
    end else begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      v4_d = v4_q;
    end
  end

  // Stage valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
    end
  end

  // S3 cofactor products and S4 exact sum, everything sign-extended first.
  always_comb begin
    x_d = P_W'(r0_s2_q[0]) * P_W'(m_s[0]);
    y_d = P_W'(r0_s2_q[1]) * P_W'(m_s[1]);
    z_d = P_W'(r0_s2_q[2]) * P_W'(m_s[2]);
    d_s = FULL_W'(x_q) - FULL_W'(y_q) + FULL_W'(z_q);
  end

  // Output fitting: exact widths sign-extend, narrower widths truncate and flag.
  if (OUT_W >= FULL_W) begin : g_exact
    assign det_trunc_s = OUT_W'(d_s);
    assign ovf_s       = 1'b0;
  end else begin : g_trunc
    assign det_trunc_s = d_s[OUT_W-1:0];
    assign ovf_s       = (d_s != FULL_W'(det_trunc_s));
  end

  // Datapath stage registers; everything holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) begin
        r0_s1_q[i] <= {W{1'b0}};
        r0_s2_q[i] <= {W{1'b0}};
      end
      x_q   <= {P_W{1'b0}};
      y_q   <= {P_W{1'b0}};
      z_q   <= {P_W{1'b0}};
      det_q <= {OUT_W{1'b0}};
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      for (int i = 0; i < DIM; i++) begin
        r0_s1_q[i] <= e_s[0][i];
        r0_s2_q[i] <= r0_s1_q[i];
      end
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      det_q <= det_trunc_s;
      ovf_q <= ovf_s;
    end
  end

`ifdef DET3_SINGULAR_EN
  logic sing_q;

  // Zero-determinant flag, only ever set alongside a valid result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sing_q <= 1'b0;
    end else if (adv_s) begin
      sing_q <= v3_q && (d_s == {FULL_W{1'b0}});
    end
  end

  assign bus.out_singular = sing_q;
`endif

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v4_q;
  assign bus.out_det   = det_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_det3_pipe.sv
// Directed bench for det3_pipe: a W=32 exact instance and a W=8/OUT_W=16 instance.
module tb_det3_pipe;
  import det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  det3_pipe_if #(.W(32))             bus32 ();
  det3_pipe_if #(.W(8), .OUT_W(16))  bus8 ();

  det3_pipe #(.W(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  det3_pipe #(.W(8), .OUT_W(16)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          out_cyc[$];
  logic [97:0] exp_q[$];
  logic [97:0] cur_exp = 98'd0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [97:0] e98(input longint v);
    logic signed [97:0] t;
    t = 98'(v);
    return t;
  endfunction

  function automatic logic [287:0] mk32(input int a, input int b, input int c,
                                        input int d, input int e, input int f,
                                        input int g, input int h, input int i);
    int v[9];
    logic [287:0] m;
    v = '{a, b, c, d, e, f, g, h, i};
    m = 288'd0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        m[elem_lsb(r, k, 32) +: 32] = v[3*r+k];
    return m;
  endfunction

  function automatic logic [71:0] mk8(input int a, input int b, input int c,
                                      input int d, input int e, input int f,
                                      input int g, input int h, input int i);
    int v[9];
    logic [71:0] m;
    v = '{a, b, c, d, e, f, g, h, i};
    m = 72'd0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        m[elem_lsb(r, k, 8) +: 8] = v[3*r+k][7:0];
    return m;
  endfunction

  // Rule-of-Sarrus reference for random W=32 matrices.
  function automatic logic [97:0] ref_det32(input logic [287:0] m);
    logic signed [97:0] a[9];
    logic signed [97:0] d;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        a[3*r+k] = 98'($signed(m[elem_lsb(r, k, 32) +: 32]));
    d = a[0]*a[4]*a[8] + a[1]*a[5]*a[6] + a[2]*a[3]*a[7]
      - a[2]*a[4]*a[6] - a[0]*a[5]*a[7] - a[1]*a[3]*a[8];
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the W=32 instance: match outputs in order, record accepts.
  always @(negedge clk) begin
    logic [97:0] e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus32.out_valid && bus32.out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("det32", bus32.out_det, e);
          check("ovf32", bus32.out_ovf, 1'b0);
`ifdef DET3_SINGULAR_EN
          check("singular32", bus32.out_singular, e == 98'd0);
`endif
        end
      end
      if (bus32.in_valid && bus32.in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic send32(input logic [287:0] m, input logic [97:0] exp);
    logic got;
    got = 1'b0;
    bus32.in_matrix = m;
    bus32.in_valid = 1'b1;
    cur_exp = exp;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = bus32.in_ready;
      @(posedge clk);
      #1;
    end
    check("accept32", got, 1'b1);
  endtask

  task automatic drain32();
    bus32.in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain32", exp_q.size(), 0);
  endtask

  task automatic run8(input logic [71:0] m, input logic [15:0] exp_det, input logic exp_ovf);
    logic seen;
    seen = 1'b0;
    bus8.in_matrix = m;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        seen = 1'b1;
        check("det8", bus8.out_det, exp_det);
        check("ovf8", bus8.out_ovf, exp_ovf);
      end
    end
    check("seen8", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [287:0] m;
    int lat;
    int n_before;
    int n;
    int rv[9];

    bus32.in_valid = 1'b0;
    bus32.in_matrix = 288'd0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_matrix = 72'd0;
    bus8.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus32.out_valid, 1'b0);
    check("rst_in_ready", bus32.in_ready, 1'b1);
    check("rst_out_det", bus32.out_det, 98'd0);
    check("rst_out_ovf", bus32.out_ovf, 1'b0);
    check("rst_out_valid8", bus8.out_valid, 1'b0);
`ifdef DET3_SINGULAR_EN
    check("rst_singular", bus32.out_singular, 1'b0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Identity and latency.
    bus32.in_matrix = mk32(1, 0, 0, 0, 1, 0, 0, 0, 1);
    cur_exp = e98(1);
    bus32.in_valid = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus32.in_valid = 1'b0;
      if (bus32.out_valid && lat == 0) lat = k;
    end
    check("latency", lat, 4);

    // Sign handling, singular, extreme corner.
    send32(mk32(2, -3, 1, 2, 0, -1, 1, 4, 5), e98(49));
    send32(mk32(-2, 3, -1, 2, 0, -1, 1, 4, 5), e98(-49));
    send32(mk32(1, 2, 3, 4, 5, 6, 4, 5, 6), e98(0));
    send32(mk32(int'(32'h80000000), 0, 0, 0, int'(32'h80000000), 0, 0, 0, int'(32'h80000000)),
           98'd0 - (98'd1 << 93));
    drain32();

    // Back-to-back random matrices.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 9; j++) rv[j] = $urandom;
      m = mk32(rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7], rv[8]);
      send32(m, ref_det32(m));
    end
    drain32();
    n = out_cyc.size();
    check("b2b_span", out_cyc[n-1] - out_cyc[n-8], 7);

    // Stall with a full pipeline.
    bus32.out_ready = 1'b0;
    send32(mk32(3, 0, 0, 0, 1, 0, 0, 0, 1), e98(3));
    send32(mk32(4, 0, 0, 0, 1, 0, 0, 0, 1), e98(4));
    send32(mk32(5, 0, 0, 0, 1, 0, 0, 0, 1), e98(5));
    send32(mk32(6, 0, 0, 0, 1, 0, 0, 0, 1), e98(6));
    bus32.in_matrix = mk32(7, 0, 0, 0, 1, 0, 0, 0, 1);
    cur_exp = e98(7);
    bus32.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_in_ready", bus32.in_ready, 1'b0);
      check("stall_out_valid", bus32.out_valid, 1'b1);
      check("stall_out_det", bus32.out_det, e98(3));
    end
    bus32.out_ready = 1'b1;
    send32(mk32(7, 0, 0, 0, 1, 0, 0, 0, 1), e98(7));
    drain32();

    // Narrow output: fit, overflow, and the signed 16-bit boundary.
    run8(mk8(127, -128, 0, -128, 127, 0, 0, 0, 127), 16'h817F, 1'b0);
    run8(mk8(-128, 0, 0, 0, -128, 0, 0, 0, -128), 16'h0000, 1'b1);
    run8(mk8(32, 0, 0, 0, 32, 0, 0, 0, 32), 16'h8000, 1'b1);
    run8(mk8(-32, 0, 0, 0, 32, 0, 0, 0, 32), 16'h8000, 1'b0);

    // Reset with three matrices in flight.
    send32(mk32(5, 0, 0, 0, 1, 0, 0, 0, 1), e98(5));
    send32(mk32(6, 0, 0, 0, 1, 0, 0, 0, 1), e98(6));
    send32(mk32(7, 0, 0, 0, 1, 0, 0, 0, 1), e98(7));
    bus32.in_valid = 1'b0;
    n_before = n_out;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", bus32.out_valid, 1'b0);
    check("rst_mid_out_det", bus32.out_det, 98'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_emit", n_out, n_before);

    // Recovery, including a singular matrix with equal rows 1 and 2.
    send32(mk32(9, 8, 7, 1, 2, 3, 1, 2, 3), e98(0));
    send32(mk32(2, -3, 1, 2, 0, -1, 1, 4, 5), e98(49));
    drain32();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
